conv_rtm_rd: RTL

//  Descriptor-driven RTM reader for the conv datapath: the read-side counterpart of the write-back RTM writer.

---
 rtl/conv_rtm_rd_pkg.sv | 39 +++
 rtl/conv_rtm_rd_buf.sv | 60 ++++++
 rtl/shift_reg.sv | 33 +++
 rtl/conv_rtm_rd.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/conv_rtm_rd_pkg.sv
// conv_rtm_rd_pkg: shared sizes and types for the conv RTM reader.
//   NumBanks  - RTM banks read in parallel (`S)
//   RowBytes  - bytes per bank row (`R)
//   RtmDepth  - rows per bank (`RTM_DEPTH)
// The size macros take their defaults here when no include has set them.
// Optional feature macro: CONV_RTM_RD_STALL_CNT_EN (adds the stall_cnt port on conv_rtm_rd).
`ifndef S
`define S 4
`endif
`ifndef R
`define R 4
`endif
`ifndef RTM_DEPTH
`define RTM_DEPTH 64
`endif

package conv_rtm_rd_pkg;

  localparam int unsigned NumBanks = `S;
  localparam int unsigned RowBytes = `R;
  localparam int unsigned RtmDepth = `RTM_DEPTH;
  localparam int unsigned AddrW    = $clog2(RtmDepth);
  localparam int unsigned BankW    = RowBytes * 8;
  localparam int unsigned DataW    = NumBanks * BankW;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  // Travels alongside a RAM read so the returned row can be tagged on arrival.
  typedef struct packed {
    logic vld;
    logic mask;
    logic last;
  } tag_t;

endpackage

// File: rtl/conv_rtm_rd_buf.sv
// conv_rtm_rd_buf: synchronous output FIFO of the RTM reader; the head entry drives the beat.
//   clk     in  clock
//   rstn    in  synchronous active-low reset, empties and zeroes the storage
//   wr_en   in  push wr_data (never asserted when full: the reader's credit forbids it)
//   wr_data in  Width  entry to push
//   rd_en   in  pop the head when not empty
//   head    out Width  current head entry
//   vld     out FIFO not empty
// A push into an empty FIFO becomes visible at the head on the next cycle (no bypass).
module conv_rtm_rd_buf #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [Width-1:0] wr_data,
  input  logic             rd_en,
  output logic [Width-1:0] head,
  output logic             vld
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW-1:0] PtrOne = 1;
  localparam logic [PtrW:0]   CntOne = 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    cnt_q;
  logic             do_rd;

  assign vld   = (cnt_q != '0);
  assign do_rd = rd_en && vld;
  assign head  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + PtrOne;
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      unique case ({wr_en, do_rd})
        2'b10:   cnt_q <= cnt_q + CntOne;
        2'b01:   cnt_q <= cnt_q - CntOne;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/shift_reg.sv
// shift_reg: fixed-length delay line with synchronous active-low flush.
//   clk  in  clock
//   rstn in  synchronous active-low reset, clears every stage
//   din  in  Width  value entering the line
//   dout out Width  din delayed by Depth cycles
module shift_reg #(
  parameter int unsigned Depth = 1,
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout
);

  logic [Width-1:0] stage_q [Depth];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= din;
      for (int unsigned i = 1; i < Depth; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout = stage_q[Depth-1];

endmodule

// File: rtl/conv_rtm_rd.sv
// conv_rtm_rd: descriptor-driven RTM reader for the conv datapath.
// Pops {addr,mask,last} descriptors from a FWFT FIFO, broadcasts one read per descriptor to all
// banks, tags the returned row and streams it to the consumer over valid/ready. Masked
// descriptors skip the RAM and produce an all-zero beat. One done_pulse per job.
//   clk, rstn            clock, synchronous active-low reset
//   start_pulse          begin a job (ignored unless idle)
//   done_pulse           one cycle after the last beat of a job is accepted
//   desc_fifo_*          FWFT descriptor FIFO (rd_en combinational)
//   rtm_rd_en/rtm_rd_addr registered per-bank read request, all lanes share the address
//   rtm_dout             bank data, valid RD_LAT cycles after rtm_rd_en
//   out_data/last/vld/rdy beat stream
//   stall_cnt            only when CONV_RTM_RD_STALL_CNT_EN is defined
module conv_rtm_rd
  import conv_rtm_rd_pkg::*;
#(
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned BUF_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start_pulse,
  output logic                      done_pulse,
  output logic                      desc_fifo_rd_en,
  input  logic                      desc_fifo_empty,
  input  logic [AddrW-1:0]          desc_fifo_dout_addr,
  input  logic                      desc_fifo_dout_mask,
  input  logic                      desc_fifo_dout_last,
  output logic [NumBanks-1:0]       rtm_rd_en,
  output logic [NumBanks*AddrW-1:0] rtm_rd_addr,
  input  logic [DataW-1:0]          rtm_dout,
  output logic [DataW-1:0]          out_data,
  output logic                      out_last,
  output logic                      out_vld,
  input  logic                      out_rdy
`ifdef CONV_RTM_RD_STALL_CNT_EN
  ,
  output logic [31:0]               stall_cnt
`endif
);

  localparam int unsigned CredW = $clog2(BUF_DEPTH + 1);
  localparam logic [CredW-1:0] CredMax = CredW'(BUF_DEPTH);
  localparam logic [CredW-1:0] CredOne = 1;

  state_e                    state_q, state_d;
  logic [CredW-1:0]          credit_q, credit_d;
  logic                      done_q, done_d;
  logic [NumBanks-1:0]       rd_en_q, rd_en_d;
  logic [NumBanks*AddrW-1:0] rd_addr_q, rd_addr_d;
  logic                      pop, out_hs;
  tag_t                      tag_in, tag_out;
  logic [DataW:0]            buf_wr_data, buf_head;

  // Credit bounds the beats in flight plus buffered, so the buffer never overflows and the RAM
  // return path needs no backpressure.
  assign pop    = (state_q == StRun) && !desc_fifo_empty && (credit_q < CredMax);
  assign out_hs = out_vld && out_rdy;

  assign desc_fifo_rd_en = pop;
  assign rtm_rd_en       = rd_en_q;
  assign rtm_rd_addr     = rd_addr_q;
  assign done_pulse      = done_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_pulse) state_d = StRun;
      StRun:   if (pop && desc_fifo_dout_last) state_d = StDrain;
      StDrain: if (out_hs && out_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    done_d    = (state_q == StDrain) && out_hs && out_last;
    rd_en_d   = pop ? {NumBanks{~desc_fifo_dout_mask}} : '0;
    rd_addr_d = pop ? {NumBanks{desc_fifo_dout_addr}} : rd_addr_q;
    unique case ({pop, out_hs})
      2'b10:   credit_d = credit_q + CredOne;
      2'b01:   credit_d = credit_q - CredOne;
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StIdle;
      credit_q  <= '0;
      done_q    <= 1'b0;
      rd_en_q   <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  // One cycle for the registered request plus RD_LAT for the RAM lines the tag up with rtm_dout.
  assign tag_in = '{vld: pop, mask: desc_fifo_dout_mask, last: desc_fifo_dout_last};

  shift_reg #(
    .Depth(RD_LAT + 1),
    .Width(3)
  ) u_tag_pipe (
    .clk  (clk),
    .rstn (rstn),
    .din  (tag_in),
    .dout (tag_out)
  );

  assign buf_wr_data = {tag_out.last, tag_out.mask ? {DataW{1'b0}} : rtm_dout};

  conv_rtm_rd_buf #(
    .Depth(BUF_DEPTH),
    .Width(DataW + 1)
  ) u_buf (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (tag_out.vld),
    .wr_data (buf_wr_data),
    .rd_en   (out_rdy),
    .head    (buf_head),
    .vld     (out_vld)
  );

  assign out_last = buf_head[DataW];
  assign out_data = buf_head[DataW-1:0];

`ifdef CONV_RTM_RD_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_q <= '0;
    end else if ((state_q == StIdle) && start_pulse) begin
      stall_q <= '0;
    end else if ((state_q != StIdle) && out_vld && !out_rdy && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
